spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- Byte-oriented SPI slave in mode 0 (CPOL=0, CPHA=0), MSB first, running entirely in the system clock domain.
- Samples the external SCK, SS and MOSI lines through synchronizers and detects SCK edges.
- Shifts a received byte in on MOSI while shifting the transmit byte `din` out on MISO.
- Pulses `done` with the received byte on `dout`; sits between the pin-level SPI interface and the host-side register logic.

Parameters:
- WIDTH, 8, transfer word length in bits. `din`, `dout`, `data_d` and `data_q` are all this width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ss  input  1  slave select, active low, asynchronous to clk.
- mosi  input  1  serial data from master, asynchronous.
- sck  input  1  serial clock from master, asynchronous; required to run at no more than clk/2.
- miso  output  1  serial data to master, registered.
- done  output  1  one-cycle pulse: a full word has been received.
- din  input  WIDTH  word to transmit; captured while deselected and after every completed word.
- dout  output  WIDTH  last received word, registered; held until the next word completes.
- mosi_d  output  1  debug: first synchronizer stage of mosi.
- mosi_q  output  1  debug: synchronized mosi used for sampling.
- data_d  output  WIDTH  debug: next-state value of the shift register.
- data_q  output  WIDTH  debug: current shift register contents.

Behaviour:
- Reset (async, rst=1): all synchronizer stages, bit counter, data_q, dout, done and miso go to 0. Cleared state takes effect immediately on assertion, independent of clk.
- Synchronization:
  - ss, mosi and sck each pass through a 2-flop synchronizer.
  - sck has a third flop for edge detection.
  - rise = sck_sync && !sck_prev; fall = !sck_sync && sck_prev.
- Deselected (ss_sync=1), highest priority:
  - bit_ct <= 0; data_q <= din; miso <= din[WIDTH-1].
  - Any sck edges are ignored.
  - Deasserting SS mid-word aborts the word: no done, dout unchanged.
- Selected, rise:
  - data_d = {data_q[WIDTH-2:0], mosi_q}.
  - bit_ct increments.
  - If bit_ct was WIDTH-1:
    - dout <= {data_q[WIDTH-2:0], mosi_q};
    - done <= 1 for exactly one clk;
    - bit_ct wraps to 0;
    - data_q <= din (reloaded for the next word).
- Selected, fall: miso <= data_q[WIDTH-1]. The master therefore sees the MSB before the first rising edge and each subsequent bit after each falling edge.
- Selected, no edge: all state holds; done <= 0.
- Latency:
  - Input pin to synchronized value: 2 clk.
  - done asserts on the clk after the rise detection of the last bit.
- Back-to-back words with SS held low are supported; the counter wraps with no gap.
- data_d is the combinational next-state of data_q. mosi_d is the stage-1 flop output.

Decomposition:
- No shared package needed; WIDTH is the only constant.
- One natural sub-module: sync2, a 2-flop synchronizer with async reset, instantiated for ss, mosi and sck.
- Edge detect, bit counter and shift logic live in spi_slave.

Test Plan:
- Reset: rst=1 for 1 clk with ss=1 → miso=0, done=0, dout=0x00, data_q=0x00. Release rst, ss=1, din=0xFF → data_q=0xFF and miso=1 within 3 clk.
- All-ones receive: din=0xFF; ss=0; sck and mosi both toggle on every clk from 0 (mosi=1 at every sck rise) → after 8 rises, done pulses once for 1 clk, dout=0xFF. done repeats every 16 clk while ss stays low.
- Pattern receive: master sends 0xA5 MSB first with sck period 8 clk → dout=0xA5, single done pulse. A second word 0x3C back-to-back → dout=0x3C.
- Transmit: din=0x96, ss=0, 8 sck cycles → bits sampled by master on sck rise are 1,0,0,1,0,1,1,0.
- Abort: ss=0, 5 sck rises, then ss=1 → no done, dout unchanged. The next full 8-bit transfer completes correctly from bit 0.
- Async reset mid-word: assert rst between clk edges after 4 bits → outputs clear immediately. After release, a full word is received correctly.

Source files
------------

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2 -- two-flop synchronizer with asynchronous active-high reset.
//
// Brings an asynchronous input into the clk domain. Both stages are exposed:
// q1 is the first (possibly metastable) stage, q is the settled output.
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active high; both stages clear to 0
//   d    in   asynchronous input
//   q1   out  first synchronizer stage
//   q    out  synchronized output (two clk of latency)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q1,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs at the same edge; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave -- byte-oriented SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// The SPI pins are oversampled in the system clock domain: ss, mosi and sck
// are synchronized, sck edges are detected with a third flop, and the shift
// register advances on detected edges. sck must run at no more than clk/2.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active high
//   ss      in   slave select, active low (asynchronous)
//   mosi    in   serial data from master (asynchronous)
//   sck     in   serial clock from master (asynchronous)
//   miso    out  serial data to master, registered
//   done    out  one-clk pulse when a full word has been received
//   din     in   word to transmit; loaded while deselected and after each word
//   dout    out  last received word, held until the next word completes
//   mosi_d  out  debug: first synchronizer stage of mosi
//   mosi_q  out  debug: synchronized mosi used for sampling
//   data_d  out  debug: next-state value of the shift register
//   data_q  out  debug: current shift register contents
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             mosi,
  input  logic             sck,
  output logic             miso,
  output logic             done,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             mosi_d,
  output logic             mosi_q,
  output logic [WIDTH-1:0] data_d,
  output logic [WIDTH-1:0] data_q
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic          ss_s1;
  logic          ss_sync;
  logic          sck_s1;
  logic          sck_sync;
  logic          sck_prev;
  logic          rise;
  logic          fall;
  logic [CW-1:0] bit_ct;

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  sync2 u_sync_ss (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q1  (ss_s1),
    .q   (ss_sync)
  );

  sync2 u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (mosi),
    .q1  (mosi_d),
    .q   (mosi_q)
  );

  sync2 u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d   (sck),
    .q1  (sck_s1),
    .q   (sck_sync)
  );

  // First stages of ss and sck are only meaningful inside the synchronizer.
  logic unused_stage1;
  assign unused_stage1 = &{1'b0, ss_s1, sck_s1};

  // mosi travels through the same two stages as sck, so mosi_q is aligned
  // with the sck_sync edge that samples it.
  assign rise = sck_sync & ~sck_prev;
  assign fall = ~sck_sync & sck_prev;

  // ---------------------------------------------------------------------------
  // Shift register next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    data_d = data_q;
    if (ss_sync) begin
      data_d = din;
    end else if (rise) begin
      data_d = {data_q[WIDTH-2:0], mosi_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Edge tracking, bit counter, shift register and outputs
  // ---------------------------------------------------------------------------
  // NOTE: the reset clears every register here, including the data-path
  // words dout and data_q; there is no memory array, so nothing is left
  // uninitialised after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_prev <= 1'b0;
      bit_ct   <= '0;
      data_q   <= '0;
      dout     <= '0;
      done     <= 1'b0;
      miso     <= 1'b0;
    end else begin
      sck_prev <= sck_sync;
      done     <= 1'b0;

      if (ss_sync) begin
        // Deselected: park on a fresh transmit word and ignore sck entirely.
        // Leaving mid-word drops the partial word without a done pulse.
        bit_ct <= '0;
        data_q <= data_d;
        miso   <= din[WIDTH-1];
      end else if (rise) begin
        if (bit_ct == LAST_BIT) begin
          bit_ct <= '0;
          dout   <= data_d;
          done   <= 1'b1;
          // Reload straight away so the next word can follow with no gap.
          data_q <= din;
        end else begin
          bit_ct <= bit_ct + CW'(1);
          data_q <= data_d;
        end
      end else if (fall) begin
        // Mode 0: present the next bit after the falling edge so it is
        // stable for the master's next rising edge.
        miso <= data_q[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave -- self-checking bench for spi_slave.
//
// A behavioural SPI master drives the pins on falling clk edges; a monitor
// records every done pulse with the dout value and cycle number. Expected
// values come from the transfer rules: the slave must return the byte the
// master shifted out, and the master must see din MSB first.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ss;
  logic             mosi;
  logic             sck;
  logic             miso;
  logic             done;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             mosi_d;
  logic             mosi_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  spi_slave #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .ss     (ss),
    .mosi   (mosi),
    .sck    (sck),
    .miso   (miso),
    .done   (done),
    .din    (din),
    .dout   (dout),
    .mosi_d (mosi_d),
    .mosi_q (mosi_q),
    .data_d (data_d),
    .data_q (data_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Done monitor: log every pulse and flag pulses longer than one clk.
  logic       done_prev = 1'b0;
  int         done_cnt  = 0;
  int         long_done = 0;
  logic [7:0] rx_q[$];
  int         cyc_q[$];

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      rx_q.push_back(dout);
      cyc_q.push_back(cyc);
      if (done_prev === 1'b1) long_done++;
    end
    done_prev = done;
  end

  // Reference: last word the slave should report on dout.
  logic [7:0] exp_dout;

  // ---------------------------------------------------------------------------
  // Master helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of tx out MSB first with sck half-period of `half` clk;
  // returns the miso bits seen at each rising sck edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                          output logic [7:0] seen);
    seen = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clks(half);
      sck  = 1'b1;
      seen = {seen[6:0], miso};
      wait_clks(half);
      sck  = 1'b0;
    end
  endtask

  task automatic select_with(input logic [7:0] d);
    din = d;
    ss  = 1'b1;
    wait_clks(4);
    ss  = 1'b0;
    wait_clks(4);
  endtask

  task automatic deselect();
    wait_clks(6);
    ss = 1'b1;
    wait_clks(4);
  endtask

  // Bounded wait for the done counter to reach target.
  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 20) begin
      @(negedge clk);
      k++;
    end
    wait_clks(2);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst  = 1'b1;
    ss   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    din  = 8'h00;
    wait_clks(1);
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_checks++;
    if (data_q !== 8'h00) begin n_fail++; $display("FAIL reset_data_q: got %h expected 00", data_q); end
    rst = 1'b0;
    din = 8'hFF;
    wait_clks(3);
    n_checks++;
    if (data_q !== 8'hFF) begin n_fail++; $display("FAIL idle_load_data_q: got %h expected ff", data_q); end
    n_checks++;
    if (miso !== 1'b1) begin n_fail++; $display("FAIL idle_load_miso: got %b expected 1", miso); end
    exp_dout = 8'h00;
  endtask

  task automatic test_all_ones();
    int base;
    int idx;
    din = 8'hFF;
    ss  = 1'b0;
    wait_clks(4);
    base = done_cnt;
    idx  = rx_q.size();
    for (int t = 0; t < 48; t++) begin
      @(negedge clk);
      sck  = ~sck;
      mosi = sck;
    end
    wait_clks(6);
    n_checks++;
    if (done_cnt - base !== 3) begin
      n_fail++; $display("FAIL ones_done_count: got %0d expected 3", done_cnt - base);
    end
    if (rx_q.size() >= idx + 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx_q[idx+i] !== 8'hFF) begin
          n_fail++; $display("FAIL ones_dout[%0d]: got %h expected ff", i, rx_q[idx+i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (cyc_q[idx+i] - cyc_q[idx+i-1] !== 16) begin
          n_fail++; $display("FAIL ones_spacing[%0d]: got %0d expected 16",
                             i, cyc_q[idx+i] - cyc_q[idx+i-1]);
        end
      end
    end
    n_checks++;
    if (long_done !== 0) begin n_fail++; $display("FAIL ones_pulse_width: got %0d long pulses expected 0", long_done); end
    exp_dout = 8'hFF;
    sck  = 1'b0;
    mosi = 1'b0;
    deselect();
  endtask

  task automatic test_pattern();
    logic [7:0] d;
    logic [7:0] seen1;
    logic [7:0] seen2;
    int base;
    int idx;
    d    = 8'($urandom);
    base = done_cnt;
    idx  = rx_q.size();
    select_with(d);
    spi_bits(8'hA5, 8, 4, seen1);
    spi_bits(8'h3C, 8, 4, seen2);
    wait_done(base + 2);
    n_checks++;
    if (done_cnt - base !== 2) begin n_fail++; $display("FAIL pattern_done_count: got %0d expected 2", done_cnt - base); end
    if (rx_q.size() >= idx + 2) begin
      n_checks++;
      if (rx_q[idx] !== 8'hA5) begin n_fail++; $display("FAIL pattern_word0: got %h expected a5", rx_q[idx]); end
      n_checks++;
      if (rx_q[idx+1] !== 8'h3C) begin n_fail++; $display("FAIL pattern_word1: got %h expected 3c", rx_q[idx+1]); end
    end
    exp_dout = 8'h3C;
    n_checks++;
    if (dout !== exp_dout) begin n_fail++; $display("FAIL pattern_dout: got %h expected %h", dout, exp_dout); end
    n_checks++;
    if (seen1 !== d) begin n_fail++; $display("FAIL pattern_miso0: got %h expected %h", seen1, d); end
    n_checks++;
    if (seen2 !== d) begin n_fail++; $display("FAIL pattern_miso1: got %h expected %h", seen2, d); end
    deselect();
  endtask

  task automatic test_transmit();
    logic [7:0] m;
    logic [7:0] seen;
    int base;
    m    = 8'($urandom);
    base = done_cnt;
    select_with(8'h96);
    spi_bits(m, 8, 4, seen);
    wait_done(base + 1);
    n_checks++;
    if (seen !== 8'b1001_0110) begin n_fail++; $display("FAIL transmit_bits: got %b expected 10010110", seen); end
    exp_dout = m;
    n_checks++;
    if (dout !== exp_dout) begin n_fail++; $display("FAIL transmit_dout: got %h expected %h", dout, exp_dout); end
    deselect();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] seen;
    int half;
    int base;
    for (int it = 0; it < 6; it++) begin
      d    = 8'($urandom);
      m    = 8'($urandom);
      half = $urandom_range(3, 6);
      base = done_cnt;
      select_with(d);
      spi_bits(m, 8, half, seen);
      wait_done(base + 1);
      exp_dout = m;
      n_checks++;
      if (done_cnt - base !== 1) begin n_fail++; $display("FAIL random%0d_done: got %0d expected 1", it, done_cnt - base); end
      n_checks++;
      if (dout !== exp_dout) begin n_fail++; $display("FAIL random%0d_dout: got %h expected %h", it, dout, exp_dout); end
      n_checks++;
      if (seen !== d) begin n_fail++; $display("FAIL random%0d_miso: got %h expected %h", it, seen, d); end
      deselect();
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] seen;
    int base;
    base = done_cnt;
    select_with(8'($urandom));
    spi_bits(8'($urandom), 5, 4, seen);
    wait_clks(6);
    ss = 1'b1;
    wait_clks(6);
    n_checks++;
    if (done_cnt !== base) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - base); end
    n_checks++;
    if (dout !== exp_dout) begin n_fail++; $display("FAIL abort_dout_held: got %h expected %h", dout, exp_dout); end
    d = 8'($urandom);
    m = 8'($urandom);
    select_with(d);
    spi_bits(m, 8, 4, seen);
    wait_done(base + 1);
    exp_dout = m;
    n_checks++;
    if (dout !== exp_dout) begin n_fail++; $display("FAIL abort_next_dout: got %h expected %h", dout, exp_dout); end
    n_checks++;
    if (seen !== d) begin n_fail++; $display("FAIL abort_next_miso: got %h expected %h", seen, d); end
    deselect();
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] seen;
    int base;
    select_with(8'hFF);
    spi_bits(8'hF0, 4, 4, seen);
    // Assert reset between clk edges and look before the next edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL areset_miso: got %b expected 0", miso); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b expected 0", done); end
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL areset_dout: got %h expected 00", dout); end
    n_checks++;
    if (data_q !== 8'h00) begin n_fail++; $display("FAIL areset_data_q: got %h expected 00", data_q); end
    exp_dout = 8'h00;
    wait_clks(2);
    ss   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    rst  = 1'b0;
    wait_clks(2);
    d    = 8'($urandom);
    m    = 8'($urandom);
    base = done_cnt;
    select_with(d);
    spi_bits(m, 8, 4, seen);
    wait_done(base + 1);
    exp_dout = m;
    n_checks++;
    if (dout !== exp_dout) begin n_fail++; $display("FAIL areset_next_dout: got %h expected %h", dout, exp_dout); end
    n_checks++;
    if (seen !== d) begin n_fail++; $display("FAIL areset_next_miso: got %h expected %h", seen, d); end
    deselect();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern();
    test_transmit();
    test_random();
    test_abort();
    test_async_reset();
    n_checks++;
    if (long_done !== 0) begin n_fail++; $display("FAIL done_width_overall: got %0d long pulses expected 0", long_done); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
